// File: rtl/shift_seq_pkg.sv
// Shared types for the shift_seq_ctrl parallel-to-serial sequencer.
// Optional build macro: SHIFT_SEQ_PARITY_EN appends one even-parity bit to every frame.
package shift_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int DIR_LEFT  = 0;
  localparam int DIR_RIGHT = 1;

`ifdef SHIFT_SEQ_PARITY_EN
  localparam int PARITY_BITS = 1;
`else
  localparam int PARITY_BITS = 0;
`endif

  // Serial bits per frame for a given word width.
  function automatic int frame_bits(input int width);
    return width + PARITY_BITS;
  endfunction

endpackage

// File: rtl/shift_seq_if.sv
// Word-producer handshake bundle feeding the serial sequencer.
// A word moves on the rising edge where in_valid and in_ready are both high (and the sequencer is enabled).
interface shift_seq_if #(
  parameter int W = 8
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;

  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/shift_seq_datapath.sv
// Shift register, clock divider, bit counter and optional parity bit for shift_seq_ctrl.
// Optional build macro: SHIFT_SEQ_PARITY_EN.
module shift_seq_datapath
  import shift_seq_pkg::*;
#(
  parameter int SHIFT_WIDTH     = 8,
  parameter int SHIFT_DIRECTION = DIR_LEFT,
  parameter int CLK_DIV         = 1
) (
  input  logic                   clock,
  input  logic                   sclr,
  input  logic                   load,
  input  logic [SHIFT_WIDTH-1:0] data,
  input  logic                   run,
  input  logic                   clear,
  output logic                   ser_bit,
  output logic                   last_tick
);

  localparam int NBITS = frame_bits(SHIFT_WIDTH);
  localparam int DIV_W = $clog2(CLK_DIV + 1);
  localparam int BIT_W = $clog2(NBITS + 1);

  logic [SHIFT_WIDTH-1:0] shreg;
  logic [SHIFT_WIDTH-1:0] shreg_next;
  logic [DIV_W-1:0]       div_cnt;
  logic [BIT_W-1:0]       bit_cnt;
  logic                   div_end;
  logic                   data_bit;

  assign div_end   = (div_cnt == DIV_W'(CLK_DIV - 1));
  assign last_tick = div_end && (bit_cnt == BIT_W'(NBITS - 1));

  generate
    if (SHIFT_DIRECTION == DIR_RIGHT) begin : g_lsb_first
      assign data_bit   = shreg[0];
      assign shreg_next = {1'b0, shreg[SHIFT_WIDTH-1:1]};
    end else begin : g_msb_first
      assign data_bit   = shreg[SHIFT_WIDTH-1];
      assign shreg_next = {shreg[SHIFT_WIDTH-2:0], 1'b0};
    end
  endgenerate

  // The divider only advances while the FSM says the frame is running and enabled.
  always_ff @(posedge clock) begin
    if (sclr || clear) begin
      shreg   <= '0;
      div_cnt <= '0;
      bit_cnt <= '0;
    end else if (load) begin
      shreg   <= data;
      div_cnt <= '0;
      bit_cnt <= '0;
    end else if (run) begin
      if (div_end) begin
        div_cnt <= '0;
        bit_cnt <= bit_cnt + BIT_W'(1);
        shreg   <= shreg_next;
      end else begin
        div_cnt <= div_cnt + DIV_W'(1);
      end
    end
  end

`ifdef SHIFT_SEQ_PARITY_EN
  logic parity;

  always_ff @(posedge clock) begin
    if (sclr || clear) begin
      parity <= 1'b0;
    end else if (load) begin
      parity <= ^data;
    end
  end

  // Once all data bits have gone out, the slot after them carries the parity.
  assign ser_bit = (bit_cnt == BIT_W'(SHIFT_WIDTH)) ? parity : data_bit;
`else
  assign ser_bit = data_bit;
`endif

endmodule

// File: rtl/shift_seq_ctrl.sv
// Parallel-to-serial transmit sequencer: handshake + IDLE/SHIFT/DONE FSM around shift_seq_datapath.
// Optional build macro: SHIFT_SEQ_PARITY_EN (extra even-parity bit per frame).
module shift_seq_ctrl
  import shift_seq_pkg::*;
#(
  parameter int SHIFT_WIDTH     = 8,
  parameter int SHIFT_DIRECTION = DIR_LEFT,
  parameter int CLK_DIV         = 1
) (
  input  logic       clock,
  input  logic       sclr,
  input  logic       enable,
  input  logic       abort,
  shift_seq_if.slave in_if,
  output logic       ser_out,
  output logic       ser_valid,
  output logic       busy,
  output logic       done,
  output state_t     state_dbg
);

  state_t state;
  state_t state_next;
  logic   accept;
  logic   run;
  logic   clear;
  logic   ser_bit;
  logic   last_tick;

  // in_ready is a pure function of state; a word is taken only on an enabled
  // edge with in_valid & in_ready, so the producer must hold valid/data until then.
  assign in_if.in_ready = (state != SHIFT);
  assign accept         = in_if.in_valid && in_if.in_ready && enable;
  assign run            = enable && (state == SHIFT) && !abort;
  assign clear          = abort && (state == SHIFT);

  always_ff @(posedge clock) begin
    if (sclr) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Abort beats completion and ignores enable.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept) state_next = SHIFT;
      end
      SHIFT: begin
        if (abort) begin
          state_next = IDLE;
        end else if (enable && last_tick) begin
          state_next = DONE;
        end
      end
      DONE: begin
        if (accept) begin
          state_next = SHIFT;
        end else if (enable) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    ser_out   = 1'b0;
    ser_valid = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      SHIFT: begin
        ser_out   = ser_bit;
        ser_valid = 1'b1;
        busy      = 1'b1;
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  assign state_dbg = state;

  shift_seq_datapath #(
    .SHIFT_WIDTH     (SHIFT_WIDTH),
    .SHIFT_DIRECTION (SHIFT_DIRECTION),
    .CLK_DIV         (CLK_DIV)
  ) u_datapath (
    .clock     (clock),
    .sclr      (sclr),
    .load      (accept),
    .data      (in_if.in_data),
    .run       (run),
    .clear     (clear),
    .ser_bit   (ser_bit),
    .last_tick (last_tick)
  );

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Bench for shift_seq_ctrl: MSB-first and LSB-first instances driven in lockstep, checked per cycle
// against an expected-observation queue built from a frame-level model.
`timescale 1ns/1ps
module tb_shift_seq_ctrl;
  import shift_seq_pkg::*;

  localparam int W   = 8;
  localparam int DIV = 2;
`ifdef SHIFT_SEQ_PARITY_EN
  localparam int NB = W + 1;
`else
  localparam int NB = W;
`endif

  // Observation record: {in_ready, busy, ser_valid, ser_out, done}
  localparam logic [4:0] IDLE_REC = 5'b10000;
  localparam logic [4:0] DONE_REC = 5'b10001;

  // ---------------- clock / reset / signals ----------------
  logic         clock = 1'b0;
  logic         sclr;
  logic         enable;
  logic         abort;
  logic         in_valid;
  logic [W-1:0] in_data;

  always #5 clock = ~clock;

  shift_seq_if #(.W(W)) bus0 ();
  shift_seq_if #(.W(W)) bus1 ();
  assign bus0.in_valid = in_valid;
  assign bus0.in_data  = in_data;
  assign bus1.in_valid = in_valid;
  assign bus1.in_data  = in_data;

  logic   ser_out0, ser_valid0, busy0, done0;
  logic   ser_out1, ser_valid1, busy1, done1;
  state_t state0, state1;

  shift_seq_ctrl #(.SHIFT_WIDTH(W), .SHIFT_DIRECTION(0), .CLK_DIV(DIV)) dut0 (
    .clock(clock), .sclr(sclr), .enable(enable), .abort(abort), .in_if(bus0),
    .ser_out(ser_out0), .ser_valid(ser_valid0), .busy(busy0), .done(done0), .state_dbg(state0)
  );

  shift_seq_ctrl #(.SHIFT_WIDTH(W), .SHIFT_DIRECTION(1), .CLK_DIV(DIV)) dut1 (
    .clock(clock), .sclr(sclr), .enable(enable), .abort(abort), .in_if(bus1),
    .ser_out(ser_out1), .ser_valid(ser_valid1), .busy(busy1), .done(done1), .state_dbg(state1)
  );

  // ---------------- scoreboard ----------------
  logic [4:0] exp_q0[$];
  logic [4:0] exp_q1[$];
  logic [4:0] last0 = IDLE_REC;
  logic [4:0] last1 = IDLE_REC;
  int checks = 0;
  int errors = 0;

  function automatic logic [4:0] shift_rec(input logic b);
    return {1'b0, 1'b1, 1'b1, b, 1'b0};
  endfunction

  // Expected frame: bit i of the serial stream, each held DIV cycles, then one done cycle.
  task automatic offer(input logic [W-1:0] w);
    logic b0, b1;
    in_valid = 1'b1;
    in_data  = w;
    for (int i = 0; i < NB; i++) begin
      b0 = (i < W) ? w[W-1-i] : ^w;
      b1 = (i < W) ? w[i]     : ^w;
      for (int k = 0; k < DIV; k++) begin
        exp_q0.push_back(shift_rec(b0));
        exp_q1.push_back(shift_rec(b1));
      end
    end
    exp_q0.push_back(DONE_REC);
    exp_q1.push_back(DONE_REC);
  endtask

  task automatic check_rec(input string tag, input logic [4:0] obs, input logic [4:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b (ready,busy,ser_valid,ser_out,done)", tag, obs, exp_v);
    end
  endtask

  task automatic tick(input string tag);
    logic [4:0] e0, e1;
    @(posedge clock);
    #1;
    e0 = (exp_q0.size() > 0) ? exp_q0.pop_front() : IDLE_REC;
    e1 = (exp_q1.size() > 0) ? exp_q1.pop_front() : IDLE_REC;
    last0 = e0;
    last1 = e1;
    check_rec({tag, "_msb"}, {bus0.in_ready, busy0, ser_valid0, ser_out0, done0}, e0);
    check_rec({tag, "_lsb"}, {bus1.in_ready, busy1, ser_valid1, ser_out1, done1}, e1);
  endtask

  task automatic freeze_cycles(input int n);
    enable = 1'b0;
    repeat (n) begin
      exp_q0.push_front(last0);
      exp_q1.push_front(last1);
    end
  endtask

  task automatic drain(input string tag);
    while (exp_q0.size() > 0) tick(tag);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [W-1:0] w;
    bit hold;
    sclr = 1'b1; enable = 1'b1; abort = 1'b0; in_valid = 1'b0; in_data = '0;

    repeat (3) @(posedge clock);
    #1;
    check_rec("reset_msb", {bus0.in_ready, busy0, ser_valid0, ser_out0, done0}, IDLE_REC);
    check_rec("reset_lsb", {bus1.in_ready, busy1, ser_valid1, ser_out1, done1}, IDLE_REC);
    sclr = 1'b0;
    tick("idle");
    tick("idle");

    // Single frame 8'hA5 in both directions.
    offer(8'hA5);
    tick("a5_accept");
    in_valid = 1'b0;
    drain("a5_frame");
    tick("a5_after");
    tick("a5_after");

    // Back-to-back: second word offered in the DONE cycle.
    offer(8'hFF);
    tick("ff_accept");
    in_valid = 1'b0;
    drain("ff_frame");
    offer(8'h00);
    tick("b2b_accept");
    in_valid = 1'b0;
    drain("zero_frame");
    tick("b2b_after");

    // Abort while bit 3 is on the line.
    offer(8'hA5);
    tick("abort_accept");
    in_valid = 1'b0;
    repeat (3 * DIV) tick("abort_pre");
    abort = 1'b1;
    exp_q0.delete();
    exp_q1.delete();
    tick("abort_idle");
    abort = 1'b0;
    repeat (4) tick("abort_nodone");

    // Freeze 5 cycles mid-frame.
    offer(8'h3C);
    tick("frz_accept");
    in_valid = 1'b0;
    repeat (5) tick("frz_pre");
    freeze_cycles(5);
    repeat (5) tick("frz_hold");
    enable = 1'b1;
    drain("frz_frame");
    tick("frz_after");

    // Freeze in DONE: pulse stretches and an offered word is not taken.
    offer(8'h5A);
    tick("dfrz_accept");
    in_valid = 1'b0;
    drain("dfrz_frame");
    freeze_cycles(3);
    in_valid = 1'b1;
    in_data  = 8'h99;
    repeat (3) tick("dfrz_hold");
    in_valid = 1'b0;
    enable   = 1'b1;
    tick("dfrz_idle");

    // Abort while idle has no effect.
    abort = 1'b1;
    tick("abort_in_idle");
    abort = 1'b0;
    tick("abort_in_idle");

    // Synchronous clear mid-frame.
    offer(8'hC3);
    tick("sclr_accept");
    in_valid = 1'b0;
    repeat (4) tick("sclr_pre");
    sclr = 1'b1;
    exp_q0.delete();
    exp_q1.delete();
    tick("sclr_idle");
    sclr = 1'b0;
    tick("sclr_after");

    // Random frames: random gaps, random single-cycle freezes, producer
    // sometimes parks the next word (with changing data) during a frame.
    hold = 1'b0;
    for (int n = 0; n < 40; n++) begin
      if (!hold) repeat ($urandom_range(0, 3)) tick("rnd_gap");
      w = W'($urandom);
      offer(w);
      tick("rnd_accept");
      hold = ($urandom_range(0, 2) == 0);
      in_valid = hold;
      while (exp_q0.size() > 0) begin
        if (hold) in_data = W'($urandom);
        if ($urandom_range(0, 7) == 0) freeze_cycles(1);
        tick("rnd_frame");
        enable = 1'b1;
      end
    end
    in_valid = 1'b0;
    tick("rnd_end");
    tick("rnd_end");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
